// File: rtl/lcd_bus_pkg.sv
// Shared opcodes and decoder state encoding for the 8080-style LCD write-bus receiver.
package lcd_bus_pkg;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        IDLE,
        CASET,
        PASET,
        RAMWR_HI,
        RAMWR_LO,
        IGNORE
    } state_t;

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the LCD bus plus rising-edge detect on the write strobe.
module lcd_bus_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] lcd_db,
    input  logic       lcd_wr,
    input  logic       lcd_d_c,
    input  logic       lcd_reset,
    output logic       byte_evt,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       bus_rst
);

    logic [7:0] db_s1, db_s2;
    logic       wr_s1, wr_s2, wr_s3;
    logic       dc_s1, dc_s2;
    logic       rst_s1, rst_s2;

    // Strobe and bus-reset flops idle high so leaving reset never fakes an edge or a bus reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_s1  <= '0;
            db_s2  <= '0;
            dc_s1  <= 1'b0;
            dc_s2  <= 1'b0;
            wr_s1  <= 1'b1;
            wr_s2  <= 1'b1;
            wr_s3  <= 1'b1;
            rst_s1 <= 1'b1;
            rst_s2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, forming a real shift chain.
            db_s1  <= lcd_db;
            db_s2  <= db_s1;
            dc_s1  <= lcd_d_c;
            dc_s2  <= dc_s1;
            wr_s1  <= lcd_wr;
            wr_s2  <= wr_s1;
            wr_s3  <= wr_s2;
            rst_s1 <= lcd_reset;
            rst_s2 <= rst_s1;
        end
    end

    assign byte_evt  = wr_s2 & ~wr_s3;
    assign byte_data = db_s2;
    assign byte_dc   = dc_s2;
    assign bus_rst   = ~rst_s2;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Decodes the ILI9341 command subset (CASET/PASET/RAMWR/SWRESET) into a stream of RGB565 pixels with coordinates.
module lcd_bus_receiver
    import lcd_bus_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  lcd_db,
    input  logic        lcd_wr,
    input  logic        lcd_d_c,
    input  logic        lcd_reset,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_rgb,
    output logic        frame_done,
    output logic        unk_cmd,
    output logic        byte_err,
    output logic [7:0]  last_cmd
);

    localparam logic [15:0] EC_RST = 16'(H_RES - 1);
    localparam logic [15:0] EP_RST = 16'(V_RES - 1);

    logic       byte_evt, byte_dc, bus_rst;
    logic [7:0] byte_data;

    lcd_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .lcd_db    (lcd_db),
        .lcd_wr    (lcd_wr),
        .lcd_d_c   (lcd_d_c),
        .lcd_reset (lcd_reset),
        .byte_evt  (byte_evt),
        .byte_data (byte_data),
        .byte_dc   (byte_dc),
        .bus_rst   (bus_rst)
    );

    state_t      state, state_n;
    logic [15:0] sc, ec, sp, ep, sc_n, ec_n, sp_n, ep_n;
    logic [15:0] cur_x, cur_y, cur_x_n, cur_y_n;
    logic [7:0]  hi, hi_n;
    logic [1:0]  cnt, cnt_n;
    logic [23:0] arg, arg_n;
    logic        pix_valid_n, frame_done_n, unk_cmd_n, byte_err_n;
    logic [15:0] pix_x_n, pix_y_n, pix_rgb_n;
    logic [7:0]  last_cmd_n;
    logic        x_last, y_last;

    // Bus reset shares the full reset path; the synchronizer itself is only cleared by reset.
    always_ff @(posedge clk) begin
        if (reset || bus_rst) begin
            state      <= IDLE;
            sc         <= '0;
            ec         <= EC_RST;
            sp         <= '0;
            ep         <= EP_RST;
            cur_x      <= '0;
            cur_y      <= '0;
            hi         <= '0;
            cnt        <= '0;
            arg        <= '0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_rgb    <= '0;
            frame_done <= 1'b0;
            unk_cmd    <= 1'b0;
            byte_err   <= 1'b0;
            last_cmd   <= '0;
        end else begin
            state      <= state_n;
            sc         <= sc_n;
            ec         <= ec_n;
            sp         <= sp_n;
            ep         <= ep_n;
            cur_x      <= cur_x_n;
            cur_y      <= cur_y_n;
            hi         <= hi_n;
            cnt        <= cnt_n;
            arg        <= arg_n;
            pix_valid  <= pix_valid_n;
            pix_x      <= pix_x_n;
            pix_y      <= pix_y_n;
            pix_rgb    <= pix_rgb_n;
            frame_done <= frame_done_n;
            unk_cmd    <= unk_cmd_n;
            byte_err   <= byte_err_n;
            last_cmd   <= last_cmd_n;
        end
    end

    assign x_last = (cur_x >= ec);
    assign y_last = (cur_y >= ep);

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves one unassigned and infers a latch.
        state_n      = state;
        sc_n         = sc;
        ec_n         = ec;
        sp_n         = sp;
        ep_n         = ep;
        cur_x_n      = cur_x;
        cur_y_n      = cur_y;
        hi_n         = hi;
        cnt_n        = cnt;
        arg_n        = arg;
        pix_valid_n  = 1'b0;
        pix_x_n      = pix_x;
        pix_y_n      = pix_y;
        pix_rgb_n    = pix_rgb;
        frame_done_n = 1'b0;
        unk_cmd_n    = 1'b0;
        byte_err_n   = 1'b0;
        last_cmd_n   = last_cmd;

        if (byte_evt && !byte_dc) begin
            last_cmd_n = byte_data;
            cnt_n      = 2'd0;
            case (byte_data)
                CMD_CASET: state_n = CASET;
                CMD_PASET: state_n = PASET;
                CMD_RAMWR: begin
                    state_n = RAMWR_HI;
                    cur_x_n = sc;
                    cur_y_n = sp;
                end
                CMD_SWRESET: begin
                    state_n = IDLE;
                    sc_n    = '0;
                    ec_n    = EC_RST;
                    sp_n    = '0;
                    ep_n    = EP_RST;
                end
                CMD_NOP: state_n = IDLE;
                default: begin
                    state_n   = IGNORE;
                    unk_cmd_n = 1'b1;
                end
            endcase
        end else if (byte_evt) begin
            case (state)
                IDLE: byte_err_n = 1'b1;
                CASET, PASET: begin
                    cnt_n = cnt + 2'd1;
                    case (cnt)
                        2'd0: arg_n[23:16] = byte_data;
                        2'd1: arg_n[15:8]  = byte_data;
                        2'd2: arg_n[7:0]   = byte_data;
                        default: begin
                            // Window registers change only once all four bytes have arrived.
                            state_n = IDLE;
                            if (state == CASET) begin
                                sc_n = arg[23:8];
                                ec_n = {arg[7:0], byte_data};
                            end else begin
                                sp_n = arg[23:8];
                                ep_n = {arg[7:0], byte_data};
                            end
                        end
                    endcase
                end
                RAMWR_HI: begin
                    hi_n    = byte_data;
                    state_n = RAMWR_LO;
                end
                RAMWR_LO: begin
                    pix_valid_n  = 1'b1;
                    pix_x_n      = cur_x;
                    pix_y_n      = cur_y;
                    pix_rgb_n    = {hi, byte_data};
                    frame_done_n = x_last && y_last;
                    state_n      = RAMWR_HI;
                    if (x_last) begin
                        cur_x_n = sc;
                        cur_y_n = y_last ? sp : cur_y + 16'd1;
                    end else begin
                        cur_x_n = cur_x + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: drives 3/3-cycle bus writes and checks pixels and pulses against hand-computed values.
module tb_lcd_bus_receiver;

    // Reduced display keeps the full-frame pass well inside the cycle budget.
    localparam int TB_H = 32;
    localparam int TB_V = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  lcd_db;
    logic        lcd_wr;
    logic        lcd_d_c;
    logic        lcd_reset;
    logic        pix_valid;
    logic [15:0] pix_x, pix_y, pix_rgb;
    logic        frame_done, unk_cmd, byte_err;
    logic [7:0]  last_cmd;

    lcd_bus_receiver #(.H_RES(TB_H), .V_RES(TB_V)) dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_db     (lcd_db),
        .lcd_wr     (lcd_wr),
        .lcd_d_c    (lcd_d_c),
        .lcd_reset  (lcd_reset),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .frame_done (frame_done),
        .unk_cmd    (unk_cmd),
        .byte_err   (byte_err),
        .last_cmd   (last_cmd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] rgb;
        logic        fd;
        int          cyc;
    } pix_t;

    pix_t pix_q[$];
    int   cyc = 0;
    int   unk_cnt = 0;
    int   err_cnt = 0;
    int   fd_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_rise = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (pix_valid) pix_q.push_back('{pix_x, pix_y, pix_rgb, frame_done, cyc});
        if (unk_cmd) unk_cnt = unk_cnt + 1;
        if (byte_err) err_cnt = err_cnt + 1;
        if (frame_done) fd_cnt = fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // One bus write: strobe low 3 cycles, high 3 cycles, data held until the next fall.
    task automatic put(input logic dc, input logic [7:0] d);
        @(negedge clk);
        lcd_db  = d;
        lcd_d_c = dc;
        lcd_wr  = 1'b0;
        repeat (3) @(negedge clk);
        lcd_wr    = 1'b1;
        last_rise = cyc;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int u0, e0, f0, bad, r0, r1;
        logic [15:0] ex[5], ey[5];

        reset     = 1'b1;
        lcd_db    = 8'h00;
        lcd_wr    = 1'b1;
        lcd_d_c   = 1'b0;
        lcd_reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Reset state
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_xy", {pix_x, pix_y}, 32'd0);
        check("rst_rgb", 32'(pix_rgb), 32'd0);
        check("rst_last_cmd", 32'(last_cmd), 32'd0);
        check("rst_pulses", {29'd0, frame_done, unk_cmd, byte_err}, 32'd0);

        // Reset-default window, first two pixels and latency
        put(1'b0, 8'h2C);
        put(1'b1, 8'hF8);
        put(1'b1, 8'h00);
        r0 = last_rise;
        put(1'b1, 8'h07);
        put(1'b1, 8'hE0);
        r1 = last_rise;
        idle(3);
        check("t1_count", 32'(pix_q.size()), 32'd2);
        if (pix_q.size() == 2) begin
            check("t1_p0_xy", {pix_q[0].x, pix_q[0].y}, {16'd0, 16'd0});
            check("t1_p0_rgb", 32'(pix_q[0].rgb), 32'hF800);
            check("t1_p1_xy", {pix_q[1].x, pix_q[1].y}, {16'd1, 16'd0});
            check("t1_p1_rgb", 32'(pix_q[1].rgb), 32'h07E0);
            // Edge 0 is the first posedge after the rise, so edge 2 is the third posedge.
            check("t1_p0_latency", 32'(pix_q[0].cyc - r0), 32'd3);
            check("t1_p1_latency", 32'(pix_q[1].cyc - r1), 32'd3);
        end
        check("t1_last_cmd", 32'(last_cmd), 32'h2C);

        // Window wrap over a 2x2 window
        pix_q.delete();
        f0 = fd_cnt;
        put(1'b0, 8'h2A); put(1'b1, 8'h00); put(1'b1, 8'd10); put(1'b1, 8'h00); put(1'b1, 8'd11);
        put(1'b0, 8'h2B); put(1'b1, 8'h00); put(1'b1, 8'd5);  put(1'b1, 8'h00); put(1'b1, 8'd6);
        put(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            put(1'b1, 8'hA0);
            put(1'b1, 8'(i));
        end
        idle(3);
        ex = '{16'd10, 16'd11, 16'd10, 16'd11, 16'd10};
        ey = '{16'd5, 16'd5, 16'd6, 16'd6, 16'd5};
        check("t2_count", 32'(pix_q.size()), 32'd5);
        if (pix_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("t2_p%0d_xy", i), {pix_q[i].x, pix_q[i].y}, {ex[i], ey[i]});
                check($sformatf("t2_p%0d_fd", i), 32'(pix_q[i].fd), (i == 3) ? 32'd1 : 32'd0);
            end
            check("t2_p4_rgb", 32'(pix_q[4].rgb), 32'hA004);
        end
        check("t2_fd_count", 32'(fd_cnt - f0), 32'd1);

        // Partial CASET keeps the old window; stray data after SWRESET
        do_reset();
        pix_q.delete();
        put(1'b0, 8'h2A); put(1'b1, 8'h00); put(1'b1, 8'd20);
        put(1'b0, 8'h2C);
        put(1'b1, 8'h12); put(1'b1, 8'h34);
        put(1'b1, 8'h56); put(1'b1, 8'h78);
        idle(3);
        check("t3_count", 32'(pix_q.size()), 32'd2);
        if (pix_q.size() == 2) begin
            check("t3_p0_xy", {pix_q[0].x, pix_q[0].y}, {16'd0, 16'd0});
            check("t3_p1_xy", {pix_q[1].x, pix_q[1].y}, {16'd1, 16'd0});
            check("t3_p1_rgb", 32'(pix_q[1].rgb), 32'h5678);
        end
        e0 = err_cnt;
        put(1'b0, 8'h01);
        put(1'b1, 8'h55);
        idle(3);
        check("t3_byte_err", 32'(err_cnt - e0), 32'd1);
        check("t3_no_pixel", 32'(pix_q.size()), 32'd2);

        // Unknown command swallows its data
        pix_q.delete();
        u0 = unk_cnt;
        e0 = err_cnt;
        put(1'b0, 8'h36);
        put(1'b1, 8'h11); put(1'b1, 8'h22); put(1'b1, 8'h33);
        idle(3);
        check("t4_unk_cmd", 32'(unk_cnt - u0), 32'd1);
        check("t4_no_pixel", 32'(pix_q.size()), 32'd0);
        check("t4_no_err", 32'(err_cnt - e0), 32'd0);
        check("t4_last_cmd", 32'(last_cmd), 32'h36);

        // Bus reset mid-pixel restores window and IDLE
        put(1'b0, 8'h2A); put(1'b1, 8'h00); put(1'b1, 8'd5); put(1'b1, 8'h00); put(1'b1, 8'd8);
        put(1'b0, 8'h2B); put(1'b1, 8'h00); put(1'b1, 8'd2); put(1'b1, 8'h00); put(1'b1, 8'd4);
        put(1'b0, 8'h2C);
        put(1'b1, 8'hAB);
        @(negedge clk);
        lcd_reset = 1'b0;
        idle(4);
        lcd_reset = 1'b1;
        idle(3);
        pix_q.delete();
        e0 = err_cnt;
        put(1'b1, 8'hCD);
        put(1'b1, 8'hEF);
        idle(3);
        check("t5_no_pixel", 32'(pix_q.size()), 32'd0);
        check("t5_byte_err", 32'(err_cnt - e0), 32'd2);
        check("t5_last_cmd", 32'(last_cmd), 32'd0);
        put(1'b0, 8'h2C);
        put(1'b1, 8'h01); put(1'b1, 8'h02);
        idle(3);
        check("t5_count", 32'(pix_q.size()), 32'd1);
        if (pix_q.size() == 1) check("t5_p0_xy", {pix_q[0].x, pix_q[0].y}, {16'd0, 16'd0});

        // Full frame at minimum strobe timing over the reset-default window
        pix_q.delete();
        f0 = fd_cnt;
        put(1'b0, 8'h2C);
        for (int i = 0; i < TB_H * TB_V; i++) begin
            put(1'b1, 8'(i >> 8));
            put(1'b1, 8'(i));
        end
        idle(3);
        check("t6_count", 32'(pix_q.size()), 32'(TB_H * TB_V));
        bad = 0;
        for (int i = 0; i < pix_q.size(); i++) begin
            if (pix_q[i].x != 16'(i % TB_H) || pix_q[i].y != 16'(i / TB_H) ||
                pix_q[i].rgb != 16'(i) || pix_q[i].fd != (i == TB_H * TB_V - 1))
                bad++;
        end
        check("t6_sequence_errors", 32'(bad), 32'd0);
        if (pix_q.size() > 0) begin
            check("t6_last_xy", {pix_q[$].x, pix_q[$].y}, {16'(TB_H - 1), 16'(TB_V - 1)});
            check("t6_last_fd", 32'(pix_q[$].fd), 32'd1);
        end
        check("t6_fd_count", 32'(fd_cnt - f0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
